dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port, word-addressed data memory (256 × 32, synchronous write, registered 1-cycle read, RD high-Z when not reading) among `NREQ` requesters, e.g. the core load/store unit and a program-loader/debug port. Arbitration is round-robin, with an optional bus lock for atomic read-modify-write sequences, protected by a lock timeout. Misaligned or out-of-range accesses are rejected without touching memory. The block sits between the requesters and the memory's `A`/`WD`/`WE`/`RE`/`RD` pins.

## Interface
- `NREQ`, 2: number of requesters; legal values 2..4.
- `MEM_WORDS`, 256: memory depth in 32-bit words; must be a power of 2.
- `LOCK_MAX`, 16: maximum number of cycles a lock may be held.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot grant; a beat is accepted when `req_valid[i] & req_ready[i]`.
- `req_we`  in  NREQ  1 = write, 0 = read.
- `req_lock`  in  NREQ  hold the grant after this beat.
- `req_addr`  in  NREQ×32  byte address.
- `req_wdata`  in  NREQ×32  write data.
- `rsp_valid`  out  NREQ  one-hot response strobe.
- `rsp_err`  out  1  response is an error; qualified by `rsp_valid`.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `lock_abort`  out  NREQ  one-cycle pulse when a lock is forcibly released.
- `mem_a`  out  32  to memory `A`.
- `mem_wd`  out  32  to memory `WD`.
- `mem_we`  out  1  to memory `WE`.
- `mem_re`  out  1  to memory `RE`.
- `mem_rd`  in  32  from memory `RD`.

## Operation
**States:** `ARB` (unlocked) and `LOCKED` (owner held in `lock_owner`).

**ARB**
- Grant the first valid requester at or after the round-robin pointer `rr_ptr`.
- On acceptance, set `rr_ptr` to (granted + 1) mod NREQ.

**LOCKED**
- Only `lock_owner` may be granted; all other `req_ready` bits are 0 and `rr_ptr` is frozen.

**Lock transitions**
- Enter `LOCKED` when an accepted beat has `req_lock=1` (from either state; the counter resets to 0 on each such beat).
- Return to `ARB` when the owner completes an accepted beat with `req_lock=0`. `rr_ptr` then advances past the owner.
- Lock counter: increments every cycle in `LOCKED`. When it reaches `LOCK_MAX`:
  - force `ARB`;
  - pulse `lock_abort[owner]`;
  - advance `rr_ptr` past the owner;
  - no grant is issued in that cycle.

**Address check** on each accepted beat:
- Error if `addr[1:0]!=0` or `addr[31:2] >= MEM_WORDS`.
- An error beat drives `mem_we=mem_re=0`, yields `rsp_err=1` and `rsp_rdata=0`, and does not change lock state.

**Memory drive** (combinational from the accepted beat):
- `mem_a=req_addr[g]`, `mem_wd=req_wdata[g]`.
- `mem_we = req_we & ~err`, `mem_re = ~req_we & ~err`.
- With no accepted beat: `mem_we=mem_re=0`, `mem_a=mem_wd=0`.

**Response register**
- Captures owner, kind and error at acceptance.
- `rsp_rdata` takes `mem_rd` only for a successful read. Otherwise it is 0, so the high-Z RD never propagates.
- Responses cannot be back-pressured; requesters must always accept them.

## Timing
- Beat accepted in cycle T: memory samples at the end of T. `rsp_valid[i]`, `rsp_err` and `rsp_rdata` are valid throughout T+1.
- Read latency: 1 cycle. Write acknowledge and error response: 1 cycle.
- Throughput: one beat per cycle, back-to-back across or within requesters.
- `req_ready` is combinational from `req_valid`, the state and `rr_ptr`. It does not depend on `req_addr`.
- Reset values (immediate, asynchronous):
  - `req_ready=0`, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `lock_abort=0`;
  - `mem_we=mem_re=0`, `mem_a=mem_wd=0`;
  - state `ARB`, `rr_ptr=0`, lock counter 0.
- Reset mid-operation:
  - Reset asserted before a clock edge suppresses that edge's write.
  - A pending response is dropped; no `rsp_valid` appears after release.
  - The first grant after release goes to the lowest-index valid requester.
- Simultaneous requests with no lock: strict alternation across cycles.
- Owner drops `req_valid` while `LOCKED`: no grants are issued and the counter keeps running toward abort.

## Structure
- Package `dmem_arb_pkg`:
  - `arb_state_t` enum {ARB, LOCKED};
  - default `MEM_WORDS` and `LOCK_MAX`;
  - a `mem_req_t` struct {we, lock, addr, wdata}.
- Sub-module `rr_arbiter`: combinational NREQ-way round-robin picker.
  - Inputs: `valid` vector, `ptr`, `mask`.
  - Outputs: one-hot `grant`, `grant_idx`.
- `dmem_arbiter` holds the FSM, lock counter, address check and response register.

## Test plan
- **Write then read:** requester 0 writes 0xDEADBEEF to 0x10, then reads 0x10. Expect `rsp_valid[0]` at T+1 each time and `rsp_rdata=0xDEADBEEF`; the write response has `rsp_rdata=0`.
- **Round-robin:** both requesters hold reads of 0x0 and 0x4 for 6 cycles. Expect grants 0,1,0,1,0,1 and responses tagged to the matching requester one cycle later.
- **Lock:** requester 1 reads 0x8 with `lock=1`, then writes 0x8 with `lock=0`, while requester 0 is valid throughout. Expect requester 0 to receive no grant until after requester 1's write, then requester 0 granted next.
- **Lock timeout:** requester 0 locks, then idles with `LOCK_MAX=16`. Expect `lock_abort[0]` pulsed in cycle 16, no grant in that cycle, and requester 1 granted the following cycle.
- **Errors:** read 0x3 and write 0x400. Expect `rsp_err=1`, `rsp_rdata=0` and `mem_we=mem_re=0`; the memory contents at 0x0 are unchanged.
- **Reset mid-operation:** assert `rst_n=0` mid-cycle during an accepted write to 0x20. Expect all outputs 0 immediately, memory at 0x20 unchanged, and no `rsp_valid` after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arb_pkg                                                    |
// | Purpose  : Shared types, defaults and helpers for the data-memory arbiter.  |
// |            arb_state_t : arbiter FSM state (ARB / LOCKED)                  |
// |            mem_req_t   : one requester's beat {we, lock, addr, wdata}      |
// |            rr_next()   : round-robin successor index                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int c_mem_words_dflt = 256;
    localparam int c_lock_max_dflt  = 16;

    typedef struct packed {
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Index following idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Purpose  : Combinational NREQ-way round-robin picker. Grants the first     |
// |            requester at or after ptr whose valid and mask bits are set.    |
// | Ports    : valid     in  NREQ  request vector                              |
// |            ptr       in  IDXW  search start index                          |
// |            mask      in  NREQ  eligibility mask                            |
// |            grant     out NREQ  one-hot grant (0 when nothing eligible)     |
// |            grant_idx out IDXW  index of the granted requester              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDXW-1:0] ptr,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

    int   w_k;
    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_k       = 0;
        for (int i = 0; i < NREQ; i++) begin
            // Walk the ring starting at ptr; wrap without a modulo operator.
            w_k = int'(ptr) + i;
            if (w_k >= NREQ) begin
                w_k = w_k - NREQ;
            end
            if (!w_found && valid[w_k] && mask[w_k]) begin
                grant[w_k] = 1'b1;
                grant_idx  = IDXW'(w_k);
                w_found    = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                    |
// | Purpose  : Shares a single-port 32-bit data memory among NREQ requesters.  |
// |            Round-robin arbitration, optional bus lock with timeout,        |
// |            rejection of misaligned / out-of-range accesses.                |
// | Ports    : clk, rst_n              clock, async active-low reset           |
// |            req_valid/ready/we/lock per-requester handshake and controls    |
// |            req_addr/req_wdata      NREQ x 32 byte address / write data     |
// |            rsp_valid/err/rdata     registered response, one cycle later    |
// |            lock_abort              pulse when a lock times out             |
// |            mem_a/wd/we/re, mem_rd  memory pins                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MEM_WORDS = c_mem_words_dflt,
    parameter int LOCK_MAX  = c_lock_max_dflt
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic               rsp_err,
    output logic [31:0]        rsp_rdata,
    output logic [NREQ-1:0]    lock_abort,
    output logic [31:0]        mem_a,
    output logic [31:0]        mem_wd,
    output logic               mem_we,
    output logic               mem_re,
    input  logic [31:0]        mem_rd
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(LOCK_MAX + 1);

    localparam logic [CNTW-1:0] c_cnt_last = CNTW'(LOCK_MAX - 1);
    localparam logic [31:0]     c_words    = 32'(MEM_WORDS);

    // Registered state
    arb_state_t      r_state;
    logic [IDXW-1:0] r_owner;
    logic [IDXW-1:0] r_rr_ptr;
    logic [CNTW-1:0] r_lock_cnt;
    logic [NREQ-1:0] r_rsp_valid;
    logic            r_rsp_err;
    logic            r_rsp_rd_ok;

    // Next-state / combinational
    arb_state_t      w_state_nxt;
    logic [IDXW-1:0] w_owner_nxt;
    logic [IDXW-1:0] w_rr_nxt;
    logic [CNTW-1:0] w_cnt_nxt;
    logic [NREQ-1:0] w_abort;
    logic [NREQ-1:0] w_mask;
    logic [IDXW-1:0] w_ptr;
    logic [NREQ-1:0] w_pick;
    logic [IDXW-1:0] w_gidx;
    logic [NREQ-1:0] w_grant;
    logic            w_accept;
    logic            w_err;
    logic            w_timeout;
    mem_req_t        w_req [NREQ];
    mem_req_t        w_sel;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_req[gi] = '{we:    req_we[gi],
                             lock:  req_lock[gi],
                             addr:  req_addr[gi*32 +: 32],
                             wdata: req_wdata[gi*32 +: 32]};
    end

    // The lock may be held for LOCK_MAX cycles; the last of them is spent
    // releasing it, so nothing is granted in that cycle.
    assign w_timeout = (r_state == LOCKED) && (r_lock_cnt == c_cnt_last);

    always_comb begin
        w_mask = '1;
        w_ptr  = r_rr_ptr;
        if (r_state == LOCKED) begin
            w_mask = '0;
            w_ptr  = r_owner;
            if (!w_timeout) begin
                w_mask[r_owner] = 1'b1;
            end
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (w_ptr),
        .mask      (w_mask),
        .grant     (w_pick),
        .grant_idx (w_gidx)
    );

    // Gating with rst_n clears the grant and memory strobes the moment reset
    // asserts, which also suppresses a write at the edge reset straddles.
    assign w_grant   = rst_n ? w_pick : '0;
    assign w_accept  = |w_grant;
    assign w_sel     = w_req[w_gidx];
    assign w_err     = w_accept &&
                       ((w_sel.addr[1:0] != 2'b00) ||
                        ({2'b00, w_sel.addr[31:2]} >= c_words));
    assign req_ready = w_grant;

    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        if (w_accept) begin
            mem_a  = w_sel.addr;
            mem_wd = w_sel.wdata;
            mem_we = w_sel.we & ~w_err;
            mem_re = ~w_sel.we & ~w_err;
        end
    end

    // FSM: next state, owner, round-robin pointer and lock counter
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_lock_cnt;
        w_abort     = '0;
        case (r_state)
            ARB: begin
                if (w_accept) begin
                    w_rr_nxt = IDXW'(rr_next(int'(w_gidx), NREQ));
                    if (w_sel.lock && !w_err) begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_gidx;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            LOCKED: begin
                if (w_timeout) begin
                    w_state_nxt      = ARB;
                    w_abort[r_owner] = 1'b1;
                    w_rr_nxt         = IDXW'(rr_next(int'(r_owner), NREQ));
                    w_cnt_nxt        = '0;
                end else begin
                    w_cnt_nxt = r_lock_cnt + CNTW'(1);
                    // Error beats leave the lock untouched.
                    if (w_accept && !w_err) begin
                        if (w_sel.lock) begin
                            w_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = ARB;
                            w_rr_nxt    = IDXW'(rr_next(int'(r_owner), NREQ));
                            w_cnt_nxt   = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    assign lock_abort = w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_lock_cnt <= w_cnt_nxt;
        end
    end

    // Response register: the memory already returns read data one cycle
    // after RE, so only the qualifiers are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rd_ok <= 1'b0;
        end else begin
            r_rsp_valid <= w_grant;
            r_rsp_err   <= w_err;
            r_rsp_rd_ok <= w_accept & ~w_sel.we & ~w_err;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    // Only a successful read forwards RD, so a floating bus never leaks out.
    assign rsp_rdata = r_rsp_rd_ok ? mem_rd : '0;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_arbiter                                                 |
// | Purpose  : Self-checking bench for dmem_arbiter (NREQ=2) with a 256x32     |
// |            memory model: table of per-cycle vectors plus hand sequences    |
// |            for lock timeout and reset mid-operation.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_we, req_lock;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  rsp_valid, lock_abort;
    logic        rsp_err, mem_we, mem_re;
    logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.NREQ(2), .MEM_WORDS(256), .LOCK_MAX(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .lock_abort (lock_abort),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rd     (mem_rd)
    );

    // Memory model: sync write, registered read, RD floats when not reading.
    logic [31:0] mem [256];
    logic [31:0] rd_q;
    logic        rd_en    = 1'b0;
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
            mem_init <= 1'b1;
        end else begin
            if (mem_we) mem[mem_a[9:2]] <= mem_wd;
            if (mem_re) rd_q <= mem[mem_a[9:2]];
        end
        rd_en <= mem_re;
    end
    assign mem_rd = rd_en ? rd_q : 32'hzzzz_zzzz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    typedef struct {
        string       name;
        logic [1:0]  v, we, lk;
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  e_rdy;
        logic        e_we, e_re;
        logic [31:0] e_a, e_wd;
        logic [1:0]  e_rv;
        logic        e_err;
        logic [31:0] e_rd;
    } row_t;

    row_t tbl[$];

    task automatic add(input string nm, input logic [1:0] v, input logic [1:0] we,
                       input logic [1:0] lk, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] e_rdy,
                       input logic e_we, input logic e_re, input logic [31:0] e_a,
                       input logic [31:0] e_wd, input logic [1:0] e_rv, input logic e_err,
                       input logic [31:0] e_rd);
        row_t r;
        r.name = nm; r.v = v; r.we = we; r.lk = lk;
        r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
        r.e_rdy = e_rdy; r.e_we = e_we; r.e_re = e_re; r.e_a = e_a; r.e_wd = e_wd;
        r.e_rv = e_rv; r.e_err = e_err; r.e_rd = e_rd;
        tbl.push_back(r);
    endtask

    // Step to the next cycle: inputs change 1 time unit after the rising
    // edge, outputs are sampled 1 unit later, well clear of the next edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Row: name | v we lk a0 a1 d0 d1 | rdy we re mem_a mem_wd | rsp_valid err rdata
        add("wr10",     2'b01, 2'b01, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0,
            2'b01, 1, 0, 32'h10, 32'hDEADBEEF, 2'b00, 0, 32'h0);
        add("rd10",     2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0,
            2'b01, 0, 1, 32'h10, 32'h0, 2'b01, 0, 32'h0);
        add("idle_a",   2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
            2'b00, 0, 0, 32'h0, 32'h0, 2'b01, 0, 32'hDEADBEEF);
        add("wr4_r1",   2'b10, 2'b10, 2'b00, 32'h0, 32'h4, 32'h0, 32'h11111111,
            2'b10, 1, 0, 32'h4, 32'h11111111, 2'b00, 0, 32'h0);
        add("rr_g0a",   2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0,
            2'b01, 0, 1, 32'h0, 32'h0, 2'b10, 0, 32'h0);
        add("rr_g1a",   2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0,
            2'b10, 0, 1, 32'h4, 32'h0, 2'b01, 0, 32'hA5A50000);
        add("rr_g0b",   2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0,
            2'b01, 0, 1, 32'h0, 32'h0, 2'b10, 0, 32'h11111111);
        add("rr_g1b",   2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0,
            2'b10, 0, 1, 32'h4, 32'h0, 2'b01, 0, 32'hA5A50000);
        add("rr_g0c",   2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0,
            2'b01, 0, 1, 32'h0, 32'h0, 2'b10, 0, 32'h11111111);
        add("rr_g1c",   2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0,
            2'b10, 0, 1, 32'h4, 32'h0, 2'b01, 0, 32'hA5A50000);
        add("pre_lk",   2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
            2'b01, 0, 1, 32'h0, 32'h0, 2'b10, 0, 32'h11111111);
        add("lk_rd8",   2'b11, 2'b00, 2'b10, 32'h0, 32'h8, 32'h0, 32'h0,
            2'b10, 0, 1, 32'h8, 32'h0, 2'b01, 0, 32'hA5A50000);
        add("lk_hold",  2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
            2'b00, 0, 0, 32'h0, 32'h0, 2'b10, 0, 32'hA5A50002);
        add("lk_wr8",   2'b11, 2'b10, 2'b00, 32'h0, 32'h8, 32'h0, 32'h22222222,
            2'b10, 1, 0, 32'h8, 32'h22222222, 2'b00, 0, 32'h0);
        add("post_lk",  2'b11, 2'b00, 2'b00, 32'h8, 32'h4, 32'h0, 32'h0,
            2'b01, 0, 1, 32'h8, 32'h0, 2'b10, 0, 32'h0);
        add("idle_b",   2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
            2'b00, 0, 0, 32'h0, 32'h0, 2'b01, 0, 32'h22222222);
        add("err_rd3",  2'b01, 2'b00, 2'b00, 32'h3, 32'h0, 32'h0, 32'h0,
            2'b01, 0, 0, 32'h3, 32'h0, 2'b00, 0, 32'h0);
        add("err_w400", 2'b01, 2'b01, 2'b00, 32'h400, 32'h0, 32'hBAD0BAD0, 32'h0,
            2'b01, 0, 0, 32'h400, 32'hBAD0BAD0, 2'b01, 1, 32'h0);
        add("rd0_chk",  2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
            2'b01, 0, 1, 32'h0, 32'h0, 2'b01, 1, 32'h0);
        add("idle_c",   2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
            2'b00, 0, 0, 32'h0, 32'h0, 2'b01, 0, 32'hA5A50000);

        // ---------------- Reset state ----------------
        rst_n = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready",  32'(req_ready),  32'h0);
        chk("rst_mem_re", 32'(mem_re),     32'h0);
        chk("rst_mem_a",  mem_a,           32'h0);
        chk("rst_rsp_v",  32'(rsp_valid),  32'h0);
        chk("rst_rdata",  rsp_rdata,       32'h0);
        chk("rst_abort",  32'(lock_abort), 32'h0);
        repeat (3) @(posedge clk);
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #3 rst_n = 1'b1;

        // ---------------- Table-driven vectors ----------------
        foreach (tbl[i]) begin
            next_cycle();
            drive(tbl[i].v, tbl[i].we, tbl[i].lk, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            #1;
            chk({tbl[i].name, ".ready"},  32'(req_ready),  32'(tbl[i].e_rdy));
            chk({tbl[i].name, ".mem_we"}, 32'(mem_we),     32'(tbl[i].e_we));
            chk({tbl[i].name, ".mem_re"}, 32'(mem_re),     32'(tbl[i].e_re));
            chk({tbl[i].name, ".mem_a"},  mem_a,           tbl[i].e_a);
            chk({tbl[i].name, ".mem_wd"}, mem_wd,          tbl[i].e_wd);
            chk({tbl[i].name, ".rsp_v"},  32'(rsp_valid),  32'(tbl[i].e_rv));
            chk({tbl[i].name, ".rsp_err"},32'(rsp_err),    32'(tbl[i].e_err));
            chk({tbl[i].name, ".rdata"},  rsp_rdata,       tbl[i].e_rd);
            chk({tbl[i].name, ".abort"},  32'(lock_abort), 32'h0);
        end

        // ---------------- Lock timeout ----------------
        next_cycle();
        drive(2'b01, 2'b00, 2'b01, 32'h0, 32'h4, 32'h0, 32'h0);
        #1;
        chk("to_lock.ready", 32'(req_ready), 32'h1);
        for (int c = 1; c <= 17; c++) begin
            next_cycle();
            drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
            #1;
            if (c == 1) begin
                chk("to_c1.rsp_v", 32'(rsp_valid), 32'h1);
                chk("to_c1.rdata", rsp_rdata, 32'hA5A50000);
            end
            chk($sformatf("to_c%0d.ready", c), 32'(req_ready), (c == 17) ? 32'h2 : 32'h0);
            chk($sformatf("to_c%0d.abort", c), 32'(lock_abort), (c == 16) ? 32'h1 : 32'h0);
        end
        next_cycle();
        drive(2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("to_after.ready", 32'(req_ready), 32'h1);
        chk("to_after.rsp_v", 32'(rsp_valid), 32'h2);
        chk("to_after.rdata", rsp_rdata, 32'h11111111);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("to_idle.rsp_v", 32'(rsp_valid), 32'h1);
        chk("to_idle.rdata", rsp_rdata, 32'hA5A50000);

        // ---------------- Reset mid-operation ----------------
        next_cycle();
        drive(2'b01, 2'b01, 2'b00, 32'h20, 32'h0, 32'h33333333, 32'h0);
        #1;
        chk("mr_pre.ready",  32'(req_ready), 32'h1);
        chk("mr_pre.mem_we", 32'(mem_we),    32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rst.ready",  32'(req_ready),  32'h0);
        chk("mr_rst.mem_we", 32'(mem_we),     32'h0);
        chk("mr_rst.mem_a",  mem_a,           32'h0);
        chk("mr_rst.mem_wd", mem_wd,          32'h0);
        chk("mr_rst.rsp_v",  32'(rsp_valid),  32'h0);
        chk("mr_rst.err",    32'(rsp_err),    32'h0);
        chk("mr_rst.abort",  32'(lock_abort), 32'h0);
        next_cycle();
        chk("mr_mem20", mem[8], 32'hA5A50008);
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            #1;
            chk($sformatf("mr_rel%0d.rsp_v", c), 32'(rsp_valid), 32'h0);
        end
        drive(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0);
        #1;
        chk("mr_first.ready", 32'(req_ready), 32'h1);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("mr_first.rsp_v", 32'(rsp_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
